// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : uart_pkg                                                    |
// | Brief  : Shared FSM state encodings, parity-mode constants and a     |
// |          parity helper for the parameterised UART receiver.          |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package uart_pkg;

  // Receiver FSM encodings; code 3'd7 is unused and recovers to IDLE.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_CLEANUP   = 3'd5;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd6;

  // PARITY_MODE values.
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Parity bit a transmitter would send for the given data XOR.
  function automatic logic expected_parity(input logic data_xor, input int mode);
    return (mode == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : uart_bit_sync                                               |
// | Brief  : Two-flop synchroniser for the asynchronous serial line.     |
// |          Both flops reset to 1 so a reset never looks like a start.  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module uart_bit_sync (
  input  logic ip_Clock,
  input  logic ip_Reset,
  input  logic ip_D,
  output logic op_Q
);

  logic r_meta;
  logic r_sync;

  // Capture the raw line, then re-register to settle metastability.
  always_ff @(posedge ip_Clock) begin
    if (ip_Reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= ip_D;
      r_sync <= r_meta;
    end
  end

  assign op_Q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : uart_rx_param                                               |
// | Brief  : Parameterised UART receiver: 5..9 data bits, none/even/odd  |
// |          parity, 1 or 2 stop bits, frame-error and break detection.  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 105,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 ip_Clock,
  input  logic                 ip_Reset,
  input  logic                 ip_Rx_Serial,
  output logic                 op_Rx_DV,
  output logic [DATA_BITS-1:0] op_Rx_Byte,
  output logic                 op_Parity_Err,
  output logic                 op_Frame_Err,
  output logic                 op_Break,
  output logic                 op_Busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] c_CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] c_CNT_HALF  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] c_LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] c_LAST_STOP = IDX_W'(STOP_BITS - 1);
  localparam logic [IDX_W-1:0] c_IDX_ONE   = IDX_W'(1);

  logic                 w_rx;
  logic                 w_par_err;

  logic [2:0]           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;       // data bit index, reused as stop bit index
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bit;
  logic                 r_stop_err;  // any non-final stop sample low
  logic                 r_any_high;  // any data/parity/stop sample high
  logic                 r_dv;
  logic [DATA_BITS-1:0] r_byte;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_brk;

  uart_bit_sync u_sync (
    .ip_Clock (ip_Clock),
    .ip_Reset (ip_Reset),
    .ip_D     (ip_Rx_Serial),
    .op_Q     (w_rx)
  );

  // Parity check on the assembled word; never flags when parity is disabled.
  always_comb begin
    w_par_err = 1'b0;
    if (PARITY_MODE != PAR_NONE) begin
      w_par_err = (r_par_bit != expected_parity(^r_shift, PARITY_MODE));
    end
  end

  // Receive FSM: mid-bit sampling, result registers and the DV pulse.
  always_ff @(posedge ip_Clock) begin
    if (ip_Reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_stop_err <= 1'b0;
      r_any_high <= 1'b0;
      r_dv       <= 1'b0;
      r_byte     <= '0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_brk      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt      <= '0;
          r_idx      <= '0;
          r_dv       <= 1'b0;
          r_stop_err <= 1'b0;
          r_any_high <= 1'b0;
          if (!w_rx) begin
            r_state <= ST_START;
          end
        end

        ST_START: begin
          // Re-check the line mid start bit so short glitches are rejected.
          if (r_cnt == c_CNT_HALF) begin
            r_cnt   <= '0;
            r_state <= w_rx ? ST_IDLE : ST_DATA;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end

        ST_DATA: begin
          if (r_cnt == c_CNT_MAX) begin
            r_cnt          <= '0;
            r_shift[r_idx] <= w_rx;
            r_any_high     <= r_any_high | w_rx;
            if (r_idx == c_LAST_DATA) begin
              r_idx   <= '0;
              r_state <= (PARITY_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              r_idx <= r_idx + c_IDX_ONE;
            end
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end

        ST_PARITY: begin
          if (r_cnt == c_CNT_MAX) begin
            r_cnt      <= '0;
            r_par_bit  <= w_rx;
            r_any_high <= r_any_high | w_rx;
            r_state    <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end

        ST_STOP: begin
          if (r_cnt == c_CNT_MAX) begin
            r_cnt <= '0;
            if (r_idx == c_LAST_STOP) begin
              // Final stop sample: publish data and flags, even on error.
              r_byte  <= r_shift;
              r_perr  <= w_par_err;
              r_ferr  <= r_stop_err | ~w_rx;
              r_brk   <= ~(r_any_high | w_rx);
              r_dv    <= 1'b1;
              r_idx   <= '0;
              r_state <= ST_CLEANUP;
            end else begin
              r_stop_err <= r_stop_err | ~w_rx;
              r_any_high <= r_any_high | w_rx;
              r_idx      <= r_idx + c_IDX_ONE;
            end
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end

        ST_CLEANUP: begin
          r_dv    <= 1'b0;
          // A low stop may be a break in progress; wait for idle first.
          r_state <= r_ferr ? ST_WAIT_HIGH : ST_IDLE;
        end

        ST_WAIT_HIGH: begin
          if (w_rx) begin
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_dv    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign op_Rx_DV      = r_dv;
  assign op_Rx_Byte    = r_byte;
  assign op_Parity_Err = r_perr;
  assign op_Frame_Err  = r_ferr;
  assign op_Break      = r_brk;
  assign op_Busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_uart_rx_param                                            |
// | Brief  : Self-checking bench for uart_rx_param: three configurations |
// |          (8N1, 7E1, 8N2), a vector table plus corner-case sequences. |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_uart_rx_param;

  localparam int CPB = 16;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } obs_t;

  typedef struct {
    int         inst;
    logic [8:0] data;
    logic       par_flip;
    logic [1:0] stops;
    logic       exp_perr;
    logic       exp_ferr;
    logic       exp_brk;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic rx_a, rx_b, rx_c;

  logic       dv_a, perr_a, ferr_a, brk_a, busy_a;
  logic [7:0] byte_a;
  logic       dv_b, perr_b, ferr_b, brk_b, busy_b;
  logic [6:0] byte_b;
  logic       dv_c, perr_c, ferr_c, brk_c, busy_c;
  logic [7:0] byte_c;

  int total = 0;
  int bad   = 0;

  obs_t got_a[$], got_b[$], got_c[$];
  obs_t exp_a[$], exp_b[$], exp_c[$];

  vec_t vecs[11];

  always #5 clk = ~clk;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_a (
    .ip_Clock(clk), .ip_Reset(rst), .ip_Rx_Serial(rx_a), .op_Rx_DV(dv_a),
    .op_Rx_Byte(byte_a), .op_Parity_Err(perr_a), .op_Frame_Err(ferr_a),
    .op_Break(brk_a), .op_Busy(busy_a));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(1)) u_b (
    .ip_Clock(clk), .ip_Reset(rst), .ip_Rx_Serial(rx_b), .op_Rx_DV(dv_b),
    .op_Rx_Byte(byte_b), .op_Parity_Err(perr_b), .op_Frame_Err(ferr_b),
    .op_Break(brk_b), .op_Busy(busy_b));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) u_c (
    .ip_Clock(clk), .ip_Reset(rst), .ip_Rx_Serial(rx_c), .op_Rx_DV(dv_c),
    .op_Rx_Byte(byte_c), .op_Parity_Err(perr_c), .op_Frame_Err(ferr_c),
    .op_Break(brk_c), .op_Busy(busy_c));

  // Record every DV pulse, sampled away from the active edge.
  always @(negedge clk) begin
    if (dv_a) got_a.push_back({9'(byte_a), perr_a, ferr_a, brk_a});
    if (dv_b) got_b.push_back({9'(byte_b), perr_b, ferr_b, brk_b});
    if (dv_c) got_c.push_back({9'(byte_c), perr_c, ferr_c, brk_c});
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int inst, input logic v);
    case (inst)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  function automatic int got_size(input int inst);
    case (inst)
      0:       return got_a.size();
      1:       return got_b.size();
      default: return got_c.size();
    endcase
  endfunction

  task automatic push_exp(input int inst, input obs_t e);
    case (inst)
      0:       exp_a.push_back(e);
      1:       exp_b.push_back(e);
      default: exp_c.push_back(e);
    endcase
  endtask

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Wait (bounded) for one observation, then pop and compare with the scoreboard.
  task automatic pop_check(input int inst, input string name);
    int   n;
    obs_t g;
    obs_t e;
    n = 0;
    while (got_size(inst) == 0 && n < 8 * CPB) begin
      @(negedge clk);
      n++;
    end
    if (got_size(inst) == 0) begin
      total++;
      bad++;
      $display("FAIL %s_dv: got no op_Rx_DV expected one pulse", name);
      case (inst)
        0:       if (exp_a.size() > 0) void'(exp_a.pop_front());
        1:       if (exp_b.size() > 0) void'(exp_b.pop_front());
        default: if (exp_c.size() > 0) void'(exp_c.pop_front());
      endcase
      return;
    end
    e = '0;
    case (inst)
      0:       begin g = got_a.pop_front(); if (exp_a.size() > 0) e = exp_a.pop_front(); end
      1:       begin g = got_b.pop_front(); if (exp_b.size() > 0) e = exp_b.pop_front(); end
      default: begin g = got_c.pop_front(); if (exp_c.size() > 0) e = exp_c.pop_front(); end
    endcase
    check({name, "_data"}, g.data, e.data);
    check({name, "_perr"}, 9'(g.perr), 9'(e.perr));
    check({name, "_ferr"}, 9'(g.ferr), 9'(e.ferr));
    check({name, "_brk"},  9'(g.brk),  9'(e.brk));
  endtask

  task automatic check_none(input int inst, input string name);
    check(name, 9'(got_size(inst)), 9'd0);
  endtask

  // Drive start, data (LSB first), optional parity and stop bits; leaves the line at the last stop value.
  task automatic send_bits(input int inst, input logic [8:0] data, input logic par_flip,
                           input logic [1:0] stops);
    int   nbits;
    int   pmode;
    int   nstop;
    logic p;
    nbits = (inst == 1) ? 7 : 8;
    pmode = (inst == 1) ? 1 : 0;
    nstop = (inst == 2) ? 2 : 1;
    set_line(inst, 1'b0);
    wait_cyc(CPB);
    for (int i = 0; i < nbits; i++) begin
      set_line(inst, data[i]);
      wait_cyc(CPB);
    end
    if (pmode != 0) begin
      p = 1'b0;
      for (int i = 0; i < nbits; i++) p ^= data[i];
      if (pmode == 2) p = ~p;
      set_line(inst, p ^ par_flip);
      wait_cyc(CPB);
    end
    for (int s = 0; s < nstop; s++) begin
      set_line(inst, stops[s]);
      wait_cyc(CPB);
    end
  endtask

  task automatic send_frame(input int inst, input logic [8:0] data, input logic par_flip,
                            input logic [1:0] stops);
    wait_cyc(2 * CPB);
    send_bits(inst, data, par_flip, stops);
    set_line(inst, 1'b1);
    wait_cyc(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    obs_t e;

    vecs[0]  = '{0, 9'h0A5, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{0, 9'h000, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{0, 9'h0FF, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{0, 9'h03C, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1, 9'h055, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1, 9'h055, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1, 9'h07F, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1, 9'h02A, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{2, 9'h096, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{2, 9'h03C, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{2, 9'h0C3, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0};

    rst  = 1'b1;
    rx_a = 1'b1;
    rx_b = 1'b1;
    rx_c = 1'b1;
    wait_cyc(5);
    @(negedge clk);
    check("rst_a_outs", {byte_a, dv_a}, 9'd0);
    check("rst_a_flags", {6'd0, perr_a, ferr_a, brk_a}, 9'd0);
    check("rst_busy", {6'd0, busy_a, busy_b, busy_c}, 9'd0);
    check("rst_b_outs", {1'b0, byte_b, dv_b}, 9'd0);
    check("rst_c_outs", {byte_c, dv_c}, 9'd0);
    rst = 1'b0;
    wait_cyc(2);

    // Table-driven frames across the three configurations.
    for (int i = 0; i < 11; i++) begin
      e = {vecs[i].data, vecs[i].exp_perr, vecs[i].exp_ferr, vecs[i].exp_brk};
      push_exp(vecs[i].inst, e);
      send_frame(vecs[i].inst, vecs[i].data, vecs[i].par_flip, vecs[i].stops);
      pop_check(vecs[i].inst, $sformatf("vec%0d", i));
      wait_cyc(CPB);
      check_none(vecs[i].inst, $sformatf("vec%0d_extra", i));
    end

    // Second stop low, then line held low: one DV, no restart until high.
    wait_cyc(2 * CPB);
    push_exp(2, {9'h03C, 1'b0, 1'b1, 1'b0});
    send_bits(2, 9'h03C, 1'b0, 2'b01);
    wait_cyc(3 * 10 * CPB);
    pop_check(2, "stop2_low");
    check_none(2, "stop2_low_no_restart");
    @(negedge clk);
    check("stop2_low_busy_held", 9'(busy_c), 9'd1);
    set_line(2, 1'b1);
    wait_cyc(4);
    @(negedge clk);
    check("stop2_low_busy_released", 9'(busy_c), 9'd0);
    push_exp(2, {9'h05A, 1'b0, 1'b0, 1'b0});
    send_frame(2, 9'h05A, 1'b0, 2'b11);
    pop_check(2, "stop2_after");

    // Break: line low for three frame times.
    wait_cyc(2 * CPB);
    push_exp(0, {9'h000, 1'b0, 1'b1, 1'b1});
    set_line(0, 1'b0);
    wait_cyc(3 * 10 * CPB);
    pop_check(0, "break");
    check_none(0, "break_single_dv");
    @(negedge clk);
    check("break_busy_held", 9'(busy_a), 9'd1);
    set_line(0, 1'b1);
    wait_cyc(4);
    @(negedge clk);
    check("break_busy_released", 9'(busy_a), 9'd0);

    // Five-cycle low glitch is rejected.
    wait_cyc(2 * CPB);
    set_line(0, 1'b0);
    wait_cyc(5);
    set_line(0, 1'b1);
    @(negedge clk);
    check("glitch_busy_rise", 9'(busy_a), 9'd1);
    n = 0;
    while (busy_a && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("glitch_busy_fall", 9'(busy_a), 9'd0);
    wait_cyc(3 * CPB);
    check_none(0, "glitch_no_dv");

    // Reset during data bit 3 abandons the frame.
    set_line(0, 1'b0);
    wait_cyc(CPB);
    set_line(0, 1'b1);
    wait_cyc(3 * CPB);
    set_line(0, 1'b0);
    wait_cyc(6);
    rst = 1'b1;
    set_line(0, 1'b1);
    wait_cyc(2);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_outs", {byte_a, dv_a}, 9'd0);
    check("midrst_flags", {5'd0, perr_a, ferr_a, brk_a, busy_a}, 9'd0);
    check("midrst_b_byte", 9'(byte_b), 9'd0);
    wait_cyc(12 * CPB);
    check_none(0, "midrst_no_dv");
    push_exp(0, {9'h081, 1'b0, 1'b0, 1'b0});
    send_frame(0, 9'h081, 1'b0, 2'b11);
    pop_check(0, "midrst_next");

    wait_cyc(CPB);
    check("scoreboard_empty", 9'(exp_a.size() + exp_b.size() + exp_c.size()), 9'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter CLKS_PER_BIT, default 105: clock cycles per UART bit (ip_Clock freq / baud); legal range 4..65535.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY_MODE, default 0: 0 = none, 1 = even, 2 = odd.
REQ-004 Parameter STOP_BITS, default 1: stop bits checked per frame; legal values 1 or 2.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 ip_Clock  input  1  sole clock; all state updates on the rising edge.
REQ-007 ip_Reset  input  1  synchronous active-high reset.
REQ-008 ip_Rx_Serial  input  1  asynchronous serial line, idle high.
REQ-009 op_Rx_DV  output  1  one-cycle pulse; frame complete, data and flags valid.
REQ-010 op_Rx_Byte  output  DATA_BITS  received data, LSB first on line, held until next op_Rx_DV.
REQ-011 op_Parity_Err  output  1  parity mismatch on last frame; valid with op_Rx_DV, held until next op_Rx_DV.
REQ-012 op_Frame_Err  output  1  any stop bit sampled low; same timing as op_Parity_Err.
REQ-013 op_Break  output  1  break detected (all data, parity and stop samples low); same timing as op_Parity_Err.
REQ-014 op_Busy  output  1  high in every state except IDLE.

Function
REQ-015 ip_Rx_Serial SHALL pass through a 2-flop synchroniser before any use; the FSM sees only the second flop.
REQ-016 States: IDLE, START, DATA, PARITY, STOP, CLEANUP, WAIT_HIGH.
REQ-017 IDLE: clear the clock counter and bit index; go to START when the synchronised line is 0.
REQ-018 START: count to (CLKS_PER_BIT-1)/2; if the line is 0, clear the counter and go to DATA, else return to IDLE (glitch reject, no op_Rx_DV).
REQ-019 DATA: sample every CLKS_PER_BIT cycles into bit index 0..DATA_BITS-1; after the last bit go to PARITY if PARITY_MODE is nonzero, else STOP.
REQ-020 PARITY: sample one bit and compare with the XOR of the data bits (even) or its inverse (odd).
REQ-021 STOP: sample STOP_BITS bits at CLKS_PER_BIT intervals; op_Frame_Err = OR of (stop sample == 0).
REQ-022 On the cycle after the final stop sample: op_Rx_DV=1; op_Rx_Byte and all flags update in that same cycle; go to CLEANUP.
REQ-023 A frame with an error SHALL still produce op_Rx_DV and data.
REQ-024 CLEANUP (1 cycle): op_Rx_DV=0; go to WAIT_HIGH if op_Frame_Err is set, else IDLE.
REQ-025 WAIT_HIGH: stay until the synchronised line is 1, then go to IDLE; a break SHALL never retrigger START.
REQ-026 Counter width = $clog2(CLKS_PER_BIT); no wrap in any state.
REQ-027 Undefined state encodings SHALL go to IDLE on the next cycle.

Reset
REQ-028 With ip_Reset high at a clock edge: state=IDLE, synchroniser flops=1, counter=0, index=0, all outputs=0.
REQ-029 Reset mid-frame SHALL abandon the frame with no op_Rx_DV; reception resumes on the next falling edge after release.

Structure
REQ-030 Package uart_pkg SHALL hold the state encodings and the PARITY_MODE constants (PAR_NONE, PAR_EVEN, PAR_ODD).
REQ-031 The synchroniser SHALL be sub-module uart_bit_sync (2 flops, reset value 1); the FSM stays in uart_rx_param.

Verification (bench uses CLKS_PER_BIT=16)
REQ-032 8N1, send 0xA5 -> one op_Rx_DV pulse, op_Rx_Byte=0xA5, all flags 0.
REQ-033 DATA_BITS=7, PARITY_MODE=1, send 0x55 with wrong parity bit 1 -> op_Rx_Byte=0x55, op_Parity_Err=1; next good frame clears it.
REQ-034 STOP_BITS=2, second stop bit low, data 0x3C -> op_Frame_Err=1, op_Rx_DV=1, then no new START until the line returns high.
REQ-035 Line held low for 3 frame times -> exactly one op_Rx_DV with op_Break=1, op_Rx_Byte=0, op_Frame_Err=1.
REQ-036 Low glitch of 5 cycles -> no op_Rx_DV, op_Busy returns to 0 within 8 cycles.
REQ-037 Assert ip_Reset in DATA at bit 3 -> no op_Rx_DV, all outputs 0; the following frame 0x81 is received correctly.
